// File: rtl/branch_resolve_cp4.sv
// rtl/branch_resolve_cp4.sv - branch resolution, 2-bit BHT prediction and mispredict redirect
//
// Resolves conditional branches in EX from the comparator flags and raises
// mispredict/flush with the corrected next PC. It also trains a direct-mapped
// table of 2-bit saturating counters that supplies the IF-stage prediction.
//
// Optional feature macro: BRANCH_RESOLVE_STATS_EN (adds branch/mispredict counters)
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   if_valid, if_pc     fetch PC to predict
//   if_pred_taken       combinational prediction for if_pc
//   ex_valid, ex_stall  EX occupancy and hold
//   ex_is_branch        EX instruction is a conditional branch
//   ex_funct3           branch type
//   ex_pc, ex_target    branch PC and taken target
//   ex_pred_taken       prediction that travelled with the instruction
//   br_un               unsigned-compare select to the comparator
//   br_eq, br_lt        comparator results
//   ex_taken            resolved outcome
//   ex_mispredict       outcome differs from prediction (unstalled cycle only)
//   redirect_pc         correct next PC
//   flush               kill younger IF/ID instructions
//   stat_branches       (optional) resolved branch count
//   stat_mispredicts    (optional) mispredict count
module branch_resolve_cp4 #(
    parameter int BHT_ENTRIES = 64,
    parameter int INDEX_LSB   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic        ex_is_branch,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    output logic        br_un,
    input  logic        br_eq,
    input  logic        br_lt,
    output logic        ex_taken,
    output logic        ex_mispredict,
    output logic [31:0] redirect_pc,
    output logic        flush
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             legal;
    logic             cond;
    logic             live;
    logic             train;
    logic [1:0]       ex_ctr;
    logic [1:0]       ex_ctr_d;

    // Only the index bits of if_pc matter; the rest are deliberately ignored.
    logic unused_if_pc;
    assign unused_if_pc = ^if_pc;

    assign if_idx = if_pc[INDEX_LSB +: IDX_W];
    assign ex_idx = ex_pc[INDEX_LSB +: IDX_W];

    assign br_un = ex_funct3[1];

    always_comb begin
        legal = 1'b1;
        cond  = 1'b0;
        case (ex_funct3)
            3'b000:  cond = br_eq;
            3'b001:  cond = ~br_eq;
            3'b100,
            3'b110:  cond = br_lt;
            3'b101,
            3'b111:  cond = ~br_lt;
            default: legal = 1'b0;
        endcase
    end

    assign live  = ex_valid & ex_is_branch & legal;
    assign train = live & ~ex_stall;

    assign ex_taken      = rst_n & live & cond;
    // Masked while stalled so a held branch flushes once, on its final EX cycle.
    assign ex_mispredict = rst_n & train & (ex_taken != ex_pred_taken);
    assign flush         = ex_mispredict;
    assign redirect_pc   = !rst_n   ? 32'd0 :
                           ex_taken ? ex_target : ex_pc + 32'd4;

    // IF reads the pre-update counter; a same-cycle write shows up next cycle.
    assign if_pred_taken = rst_n & if_valid & bht_q[if_idx][1];

    assign ex_ctr = bht_q[ex_idx];

    always_comb begin
        ex_ctr_d = ex_ctr;
        if (ex_taken) begin
            if (ex_ctr != 2'b11) ex_ctr_d = ex_ctr + 2'd1;
        end else begin
            if (ex_ctr != 2'b00) ex_ctr_d = ex_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (train) begin
            bht_q[ex_idx] <= ex_ctr_d;
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branches_q    <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else if (train) begin
            stat_branches_q <= stat_branches_q + 32'd1;
            if (ex_mispredict) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
